// File: rtl/store_port_responder.sv
// Responder end of the D$ store request port: queues granted writes in a FIFO and
// drains them one at a time onto a req/gnt/ack memory write interface.
module store_port_responder #(
  parameter int unsigned INDEX_W = 12,
  parameter int unsigned TAG_W   = 44,
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      data_req_i,
  input  logic                      data_we_i,
  input  logic                      kill_req_i,
  input  logic [INDEX_W-1:0]        address_index_i,
  input  logic [TAG_W-1:0]          address_tag_i,
  input  logic [DATA_W-1:0]         data_wdata_i,
  input  logic [DATA_W/8-1:0]       data_be_i,
  input  logic [1:0]                data_size_i,
  output logic                      data_gnt_o,
  output logic                      data_rvalid_o,
  output logic                      mem_req_o,
  output logic [TAG_W+INDEX_W-1:0]  mem_addr_o,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [DATA_W/8-1:0]       mem_be_o,
  output logic [1:0]                mem_size_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_ack_i,
  input  logic [11:0]               page_offset_i,
  output logic                      page_offset_matches_o,
  output logic                      empty_o,
  output logic [1:0]                dbg_state_o
);

  localparam int unsigned ADDR_W = TAG_W + INDEX_W;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Handshakes: store side is accepted in the cycle data_req_i & data_gnt_o; memory side
  // transfers the head entry in the cycle mem_req_o & mem_gnt_i and retires it on mem_ack_i.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  state_e state_q, state_n;

  logic [ADDR_W-1:0] addr_q  [DEPTH];
  logic [DATA_W-1:0] wdata_q [DEPTH];
  logic [BE_W-1:0]   be_q    [DEPTH];
  logic [1:0]        size_q  [DEPTH];
  logic [DEPTH-1:0]  valid_q;

  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]  count_q, count_n;
  logic              push, pop;
  logic              rvalid_q;

  logic unused_inputs;
  assign unused_inputs = ^{kill_req_i, page_offset_i[2:0]};

  // Grant looks only at the registered count, so a same-cycle pop never frees a slot.
  assign push       = data_req_i & data_we_i & (count_q < DEPTH_C);
  assign pop        = (state_q == S_WAIT) & mem_ack_i;
  assign count_n    = count_q + CNT_W'(push) - CNT_W'(pop);
  assign data_gnt_o = push;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      count_q  <= count_n;
      rvalid_q <= push;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
    end
  end

  assign data_rvalid_o = rvalid_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i]  <= '0;
        wdata_q[i] <= '0;
        be_q[i]    <= '0;
        size_q[i]  <= '0;
      end
      valid_q <= '0;
    end else begin
      if (push) begin
        addr_q[wr_ptr_q]  <= {address_tag_i, address_index_i};
        wdata_q[wr_ptr_q] <= data_wdata_i;
        be_q[wr_ptr_q]    <= data_be_i;
        size_q[wr_ptr_q]  <= data_size_i;
        valid_q[wr_ptr_q] <= 1'b1;
      end
      if (pop) valid_q[rd_ptr_q] <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n   = state_q;
    mem_req_o = 1'b0;
    unique case (state_q)
      S_IDLE: if (count_q != '0) state_n = S_REQ;
      S_REQ: begin
        mem_req_o = 1'b1;
        if (mem_gnt_i) state_n = S_WAIT;
      end
      S_WAIT: if (mem_ack_i) state_n = (count_n != '0) ? S_REQ : S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Head fields come straight from storage; the head slot cannot be overwritten while queued.
  assign mem_addr_o  = addr_q[rd_ptr_q];
  assign mem_wdata_o = wdata_q[rd_ptr_q];
  assign mem_be_o    = be_q[rd_ptr_q];
  assign mem_size_o  = size_q[rd_ptr_q];

  assign empty_o     = (count_q == '0) & (state_q == S_IDLE);
  assign dbg_state_o = state_q;

  // Entries keep matching through REQ and WAIT until their ack clears the valid bit.
  always_comb begin
    page_offset_matches_o = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (addr_q[i][11:3] == page_offset_i[11:3])) page_offset_matches_o = 1'b1;
    end
  end

  a_count_bound : assert property (@(posedge clk_i) disable iff (!rst_ni) count_q <= DEPTH_C);

  a_req_stable : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (mem_req_o && !mem_gnt_i) |=> (mem_req_o && $stable(mem_addr_o) && $stable(mem_wdata_o)));

endmodule
